// File: rtl/sc_register_car_position.sv
// -----------------------------------------------------------------------------
// sc_register_car_position
//
// Player-car register downstream of the car control state machine. Holds the
// car as an 8-bit one-hot row and applies the FSM's clear/load/shift commands.
// Every cycle it compares the car row against the bottom obstacle row of the
// road. A counted hit costs one life and starts an invulnerability window.
// Losing the last life drives the active-low lose flag back to the FSM.
//
// Ports:
//   SC_STATEMACHINE_CAR_CLOCK_50     in   1  system clock (50 MHz)
//   SC_STATEMACHINE_CAR_RESET_InLow  in   1  async reset, active-low
//   SC_REGISTER_CAR_CLEAR_InLow      in   1  0 = clear row, restore lives
//   SC_REGISTER_CAR_LOAD_InLow       in   1  0 = load INIT_POSITION
//   SC_REGISTER_CAR_SHIFT_BUS        in   2  10 right, 01 left, 00/11 hold
//   SC_REGISTER_CAR_OBSTACLE_ROW     in   8  obstacle bits in the car's row
//   SC_REGISTER_CAR_ROW_OUT          out  8  registered car row
//   SC_REGISTER_CAR_LIVES_OUT        out  2  remaining lives
//   SC_REGISTER_CAR_CRASH_OUT        out  1  one-cycle pulse per counted hit
//   SC_REGISTER_CAR_LOSE_OutLow      out  1  0 = no lives left
// -----------------------------------------------------------------------------
module sc_register_car_position #(
  parameter logic [7:0] INIT_POSITION = 8'b0001_0000,
  parameter int         MAX_LIVES     = 3,
  parameter int         GRACE_CYCLES  = 25_000_000,
  parameter int         GRACE_WIDTH   = 25
) (
  input  logic       SC_STATEMACHINE_CAR_CLOCK_50,
  input  logic       SC_STATEMACHINE_CAR_RESET_InLow,
  input  logic       SC_REGISTER_CAR_CLEAR_InLow,
  input  logic       SC_REGISTER_CAR_LOAD_InLow,
  input  logic [1:0] SC_REGISTER_CAR_SHIFT_BUS,
  input  logic [7:0] SC_REGISTER_CAR_OBSTACLE_ROW,
  output logic [7:0] SC_REGISTER_CAR_ROW_OUT,
  output logic [1:0] SC_REGISTER_CAR_LIVES_OUT,
  output logic       SC_REGISTER_CAR_CRASH_OUT,
  output logic       SC_REGISTER_CAR_LOSE_OutLow
);

  typedef enum logic [1:0] {
    SHIFT_HOLD_00 = 2'b00,
    SHIFT_LEFT    = 2'b01,
    SHIFT_RIGHT   = 2'b10,
    SHIFT_HOLD_11 = 2'b11
  } shift_e;

  localparam logic [1:0]             LIVES_FULL   = 2'(MAX_LIVES);
  localparam logic [GRACE_WIDTH-1:0] GRACE_RELOAD = GRACE_WIDTH'(GRACE_CYCLES);

  // Registered state
  logic [7:0]             row_q,     row_d;
  logic [1:0]             lives_q,   lives_d;
  logic                   crash_q,   crash_d;
  logic                   lose_n_q,  lose_n_d;
  logic [GRACE_WIDTH-1:0] grace_q,   grace_d;
  logic                   overlap_q, overlap_d;

  // Decoded inputs
  logic   clear;
  logic   load;
  logic   overlap;
  logic   hit;
  shift_e shift;

  assign clear   = ~SC_REGISTER_CAR_CLEAR_InLow;
  assign load    = ~SC_REGISTER_CAR_LOAD_InLow;
  assign shift   = shift_e'(SC_REGISTER_CAR_SHIFT_BUS);

  // Collision uses the current registered row, so a shift in the same cycle
  // does not hide a hit on the pre-shift position.
  assign overlap = |(row_q & SC_REGISTER_CAR_OBSTACLE_ROW);

  // Rising edge of overlap only: a car parked on an obstacle counts once.
  assign hit = overlap & ~overlap_q & (grace_q == '0) & lose_n_q & ~clear;

  // NOTE: every signal written here gets a default first, so no path through
  // the if/case tree leaves it unassigned and no latch is inferred.
  always_comb begin
    row_d     = row_q;
    lives_d   = lives_q;
    crash_d   = hit;
    lose_n_d  = lose_n_q;
    grace_d   = grace_q;
    overlap_d = overlap;

    // Row update: clear > load > shift > hold. Load and shift are frozen
    // once the game is lost.
    if (clear) begin
      row_d = '0;
    end else if (load) begin
      if (lose_n_q) row_d = INIT_POSITION;
    end else if (lose_n_q) begin
      unique case (shift)
        SHIFT_RIGHT: if (!row_q[0]) row_d = row_q >> 1;
        SHIFT_LEFT:  if (!row_q[7]) row_d = row_q << 1;
        default:     row_d = row_q;
      endcase
    end

    // Lives, grace window and lose flag
    if (clear) begin
      lives_d   = LIVES_FULL;
      lose_n_d  = 1'b1;
      grace_d   = '0;
      overlap_d = 1'b0;
    end else if (hit) begin
      grace_d = GRACE_RELOAD;
      if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
      if (lives_q == 2'd1) lose_n_d = 1'b0;
    end else if (grace_q != '0) begin
      grace_d = grace_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge SC_STATEMACHINE_CAR_CLOCK_50 or negedge SC_STATEMACHINE_CAR_RESET_InLow) begin
    if (!SC_STATEMACHINE_CAR_RESET_InLow) begin
      row_q     <= '0;
      lives_q   <= LIVES_FULL;
      crash_q   <= 1'b0;
      lose_n_q  <= 1'b1;
      grace_q   <= '0;
      overlap_q <= 1'b0;
    end else begin
      row_q     <= row_d;
      lives_q   <= lives_d;
      crash_q   <= crash_d;
      lose_n_q  <= lose_n_d;
      grace_q   <= grace_d;
      overlap_q <= overlap_d;
    end
  end

  assign SC_REGISTER_CAR_ROW_OUT     = row_q;
  assign SC_REGISTER_CAR_LIVES_OUT   = lives_q;
  assign SC_REGISTER_CAR_CRASH_OUT   = crash_q;
  assign SC_REGISTER_CAR_LOSE_OutLow = lose_n_q;

endmodule

// File: tb/tb_sc_register_car_position.sv
// -----------------------------------------------------------------------------
// tb_sc_register_car_position
//
// Directed bench for sc_register_car_position with a short grace window
// (GRACE_CYCLES = 4). A vector table covers load, shifts and saturation;
// hand-written sequences cover sustained overlap, the lives countdown, lose
// freeze, clear-beats-hit, the grace window and async reset mid-grace.
// -----------------------------------------------------------------------------
module tb_sc_register_car_position;

  logic       clk;
  logic       rst_n;
  logic       clear_n;
  logic       load_n;
  logic [1:0] shift;
  logic [7:0] obstacle;
  logic [7:0] row;
  logic [1:0] lives;
  logic       crash;
  logic       lose_n;

  int checks = 0;
  int errors = 0;

  sc_register_car_position #(
    .INIT_POSITION (8'b0001_0000),
    .MAX_LIVES     (3),
    .GRACE_CYCLES  (4),
    .GRACE_WIDTH   (3)
  ) dut (
    .SC_STATEMACHINE_CAR_CLOCK_50    (clk),
    .SC_STATEMACHINE_CAR_RESET_InLow (rst_n),
    .SC_REGISTER_CAR_CLEAR_InLow     (clear_n),
    .SC_REGISTER_CAR_LOAD_InLow      (load_n),
    .SC_REGISTER_CAR_SHIFT_BUS       (shift),
    .SC_REGISTER_CAR_OBSTACLE_ROW    (obstacle),
    .SC_REGISTER_CAR_ROW_OUT         (row),
    .SC_REGISTER_CAR_LIVES_OUT       (lives),
    .SC_REGISTER_CAR_CRASH_OUT       (crash),
    .SC_REGISTER_CAR_LOSE_OutLow     (lose_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clear_n;
    logic       load_n;
    logic [1:0] shift;
    logic [7:0] obstacle;
    logic [7:0] exp_row;
    logic [1:0] exp_lives;
    logic       exp_crash;
    logic       exp_lose_n;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] e_row, input logic [1:0] e_lives,
                            input logic e_crash, input logic e_lose_n);
    check({tag, ".row"},    row,           e_row);
    check({tag, ".lives"},  {6'd0, lives}, {6'd0, e_lives});
    check({tag, ".crash"},  {7'd0, crash}, {7'd0, e_crash});
    check({tag, ".lose_n"}, {7'd0, lose_n}, {7'd0, e_lose_n});
  endtask

  // Drive inputs, let one active edge pass, then sample 1 ns later.
  task automatic cycle(input logic c_n, input logic l_n, input logic [1:0] sh, input logic [7:0] ob);
    clear_n  = c_n;
    load_n   = l_n;
    shift    = sh;
    obstacle = ob;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Load and shift vectors: {clear_n, load_n, shift, obstacle, row, lives, crash, lose_n}
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 8'h00, 8'h10, 2'd3, 1'b0, 1'b1}; // load
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 8'h00, 8'h08, 2'd3, 1'b0, 1'b1}; // right
    vecs[2]  = '{1'b1, 1'b1, 2'b10, 8'h00, 8'h04, 2'd3, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 2'b10, 8'h00, 8'h02, 2'd3, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 2'b10, 8'h00, 8'h01, 2'd3, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 2'b10, 8'h00, 8'h01, 2'd3, 1'b0, 1'b1}; // saturate right
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 8'h00, 8'h10, 2'd3, 1'b0, 1'b1}; // reload
    vecs[7]  = '{1'b1, 1'b1, 2'b01, 8'h00, 8'h20, 2'd3, 1'b0, 1'b1}; // left
    vecs[8]  = '{1'b1, 1'b1, 2'b01, 8'h00, 8'h40, 2'd3, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 2'b01, 8'h00, 8'h80, 2'd3, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 2'b01, 8'h00, 8'h80, 2'd3, 1'b0, 1'b1}; // saturate left
    vecs[11] = '{1'b1, 1'b1, 2'b11, 8'h00, 8'h80, 2'd3, 1'b0, 1'b1}; // hold 11
    vecs[12] = '{1'b1, 1'b1, 2'b00, 8'h00, 8'h80, 2'd3, 1'b0, 1'b1}; // hold 00
    vecs[13] = '{1'b1, 1'b0, 2'b10, 8'h00, 8'h10, 2'd3, 1'b0, 1'b1}; // load beats shift

    rst_n    = 1'b0;
    clear_n  = 1'b1;
    load_n   = 1'b1;
    shift    = 2'b00;
    obstacle = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 8'h00, 2'd3, 1'b0, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      cycle(vecs[i].clear_n, vecs[i].load_n, vecs[i].shift, vecs[i].obstacle);
      expect_out($sformatf("vec%0d", i), vecs[i].exp_row, vecs[i].exp_lives,
                 vecs[i].exp_crash, vecs[i].exp_lose_n);
    end

    // Sustained overlap for 10 cycles counts exactly once, even past grace.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 2'b00, 8'h10);
      expect_out($sformatf("sustain%0d", i), 8'h10, 2'd2, (i == 0), 1'b1);
    end
    cycle(1'b1, 1'b1, 2'b00, 8'h00);
    expect_out("sustain_off", 8'h10, 2'd2, 1'b0, 1'b1);

    // Second hit with a right shift in the same cycle: both take effect.
    cycle(1'b1, 1'b1, 2'b10, 8'h10);
    expect_out("hit2_shift", 8'h08, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 2'b00, 8'h00);
      expect_out($sformatf("gap2_%0d", i), 8'h08, 2'd1, 1'b0, 1'b1);
    end

    // Third hit on last life: lose asserts with the crash pulse.
    cycle(1'b1, 1'b1, 2'b00, 8'h08);
    expect_out("hit3", 8'h08, 2'd0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 2'b10, 8'h00);
    expect_out("lost_shift", 8'h08, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    expect_out("lost_load", 8'h08, 2'd0, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 1'b1, 2'b00, 8'h00);
    cycle(1'b1, 1'b1, 2'b00, 8'h08);
    expect_out("lost_overlap", 8'h08, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 2'b00, 8'h00);

    // Clear after lose with an overlapping obstacle.
    cycle(1'b0, 1'b1, 2'b00, 8'h08);
    expect_out("clear_lost", 8'h00, 2'd3, 1'b0, 1'b1);

    // Clear and a would-be hit in the same cycle while alive: clear wins.
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    expect_out("reload", 8'h10, 2'd3, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 2'b00, 8'h10);
    expect_out("clear_vs_hit", 8'h00, 2'd3, 1'b0, 1'b1);

    // Grace window blocks a fresh rising overlap.
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    expect_out("reload2", 8'h10, 2'd3, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 2'b00, 8'h10);
    expect_out("grace_hit", 8'h10, 2'd2, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 2'b00, 8'h00);
    expect_out("grace_gap", 8'h10, 2'd2, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 2'b00, 8'h10);
    expect_out("grace_block", 8'h10, 2'd2, 1'b0, 1'b1);

    // Async reset mid-grace: outputs return to reset values without a clock edge.
    obstacle = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 8'h00, 2'd3, 1'b0, 1'b1);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    expect_out("post_rst_load", 8'h10, 2'd3, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 2'b00, 8'h10);
    expect_out("post_rst_hit", 8'h10, 2'd2, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
